// File: rtl/regfile.sv
`default_nettype none
//==============================================================================
// Module  : regfile
// Brief   : 32x32 register file with busy scoreboard, write bypass and a
//           registered valid/ready operand stage.
// Rev     : 1.0
//==============================================================================
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wen,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic        i_decoder_valid,
    output logic        o_regfile_ready,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic        i_claim_en,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_flush,
    output logic        o_regfile_valid,
    input  logic        i_executor_ready,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);

    logic [31:0] w_regs [0:31];
    logic [31:0] r_busy;
    logic [31:0] w_busy_next;
    logic        r_valid;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;

    logic        w_wr_en;
    logic        w_byp1;
    logic        w_byp2;
    logic        w_hz1;
    logic        w_hz2;
    logic        w_accept;
    logic [31:0] w_src1;
    logic [31:0] w_src2;

    // x0 never gets storage; it is hardwired to zero.
    assign w_wr_en   = i_wen && (i_waddr != 5'd0);
    assign w_regs[0] = 32'd0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= 32'd0;
                end else if (w_wr_en && (i_waddr == 5'(gi))) begin
                    r_q <= i_wdata;
                end
            end
            assign w_regs[gi] = r_q;
        end
    endgenerate

    // A writeback landing this cycle both resolves the hazard and feeds the operand.
    assign w_byp1 = w_wr_en && (i_waddr == i_rs1_addr);
    assign w_byp2 = w_wr_en && (i_waddr == i_rs2_addr);
    assign w_hz1  = r_busy[i_rs1_addr] && !w_byp1;
    assign w_hz2  = r_busy[i_rs2_addr] && !w_byp2;
    assign w_src1 = w_byp1 ? i_wdata : w_regs[i_rs1_addr];
    assign w_src2 = w_byp2 ? i_wdata : w_regs[i_rs2_addr];

    assign o_regfile_ready = rst_n && !i_flush && !w_hz1 && !w_hz2 &&
                             (!r_valid || i_executor_ready);
    assign w_accept        = i_decoder_valid && o_regfile_ready;

    // Clear before set so a same-cycle re-claim of the retiring index wins.
    always_comb begin
        w_busy_next = r_busy;
        if (i_flush) begin
            w_busy_next = 32'd0;
        end else begin
            if (w_wr_en) begin
                w_busy_next[i_waddr] = 1'b0;
            end
            if (w_accept && i_claim_en) begin
                w_busy_next[i_rd_addr] = 1'b1;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (r_valid && i_executor_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_rs1_data <= w_src1;
                r_rs2_data <= w_src2;
            end
        end
    end

    assign o_regfile_valid = r_valid;
    assign o_rs1_data      = r_rs1_data;
    assign o_rs2_data      = r_rs2_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
//==============================================================================
// Module  : tb_regfile
// Brief   : Self-checking bench for regfile: directed scenarios plus random
//           traffic compared every cycle against a behavioural model.
// Rev     : 1.0
//==============================================================================
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic        i_wen;
    logic [4:0]  i_waddr;
    logic [31:0] i_wdata;
    logic        i_decoder_valid;
    logic        o_regfile_ready;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        i_claim_en;
    logic [4:0]  i_rd_addr;
    logic        i_flush;
    logic        o_regfile_valid;
    logic        i_executor_ready;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    regfile u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_wen            (i_wen),
        .i_waddr          (i_waddr),
        .i_wdata          (i_wdata),
        .i_decoder_valid  (i_decoder_valid),
        .o_regfile_ready  (o_regfile_ready),
        .i_rs1_addr       (i_rs1_addr),
        .i_rs2_addr       (i_rs2_addr),
        .i_claim_en       (i_claim_en),
        .i_rd_addr        (i_rd_addr),
        .i_flush          (i_flush),
        .o_regfile_valid  (o_regfile_valid),
        .i_executor_ready (i_executor_ready),
        .o_rs1_data       (o_rs1_data),
        .o_rs2_data       (o_rs2_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;

    function automatic bit m_hazard(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !(i_wen && i_waddr == a);
    endfunction

    function automatic bit m_ready();
        return rst_n && !i_flush && !m_hazard(i_rs1_addr) && !m_hazard(i_rs2_addr) &&
               (!m_valid || i_executor_ready);
    endfunction

    function automatic logic [31:0] m_src(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (i_wen && i_waddr == a) return i_wdata;
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit          acc;
        logic [31:0] v1;
        logic [31:0] v2;
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin
                m_regs[k] = 32'd0;
                m_busy[k] = 1'b0;
            end
            m_valid = 1'b0;
            m_rs1   = 32'd0;
            m_rs2   = 32'd0;
        end else begin
            acc = i_decoder_valid && m_ready();
            v1  = m_src(i_rs1_addr);
            v2  = m_src(i_rs2_addr);
            if (i_wen && i_waddr != 0) m_regs[i_waddr] = i_wdata;
            if (i_flush) begin
                for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
                m_valid = 1'b0;
            end else begin
                if (i_wen && i_waddr != 0) m_busy[i_waddr] = 1'b0;
                if (acc && i_claim_en && i_rd_addr != 0) m_busy[i_rd_addr] = 1'b1;
                if (acc) m_valid = 1'b1;
                else if (m_valid && i_executor_ready) m_valid = 1'b0;
            end
            if (acc) begin
                m_rs1 = v1;
                m_rs2 = v2;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ready", {31'd0, o_regfile_ready}, {31'd0, m_ready()});
            check("model_valid", {31'd0, o_regfile_valid}, {31'd0, m_valid});
            check("model_rs1",   o_rs1_data, m_rs1);
            check("model_rs2",   o_rs2_data, m_rs2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_wen = 0; i_waddr = 0; i_wdata = 0;
        i_decoder_valid = 0; i_rs1_addr = 0; i_rs2_addr = 0;
        i_claim_en = 0; i_rd_addr = 0; i_flush = 0; i_executor_ready = 1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, o_regfile_ready}, 32'd0);
        check("rst_valid", {31'd0, o_regfile_valid}, 32'd0);
        check("rst_rs1",   o_rs1_data, 32'd0);
        cmp_en = 1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // write x5, read rs1=5 rs2=0
        i_wen = 1; i_waddr = 5; i_wdata = 32'hDEADBEEF;
        cyc();
        i_wen = 0; i_decoder_valid = 1; i_rs1_addr = 5; i_rs2_addr = 0;
        @(negedge clk);
        check("x5_ready", {31'd0, o_regfile_ready}, 32'd1);
        cyc();
        i_decoder_valid = 0;
        @(negedge clk);
        check("x5_valid", {31'd0, o_regfile_valid}, 32'd1);
        check("x5_rs1",   o_rs1_data, 32'hDEADBEEF);
        check("x5_rs2",   o_rs2_data, 32'd0);
        cyc();

        // write to x0 discarded
        i_wen = 1; i_waddr = 0; i_wdata = 32'h12345678;
        cyc();
        i_wen = 0; i_decoder_valid = 1; i_rs1_addr = 0; i_rs2_addr = 5;
        cyc();
        i_decoder_valid = 0;
        @(negedge clk);
        check("x0_rs1", o_rs1_data, 32'd0);
        check("x0_rs2", o_rs2_data, 32'hDEADBEEF);
        cyc();

        // claim x7, hazard until writeback, bypass on writeback cycle
        i_decoder_valid = 1; i_claim_en = 1; i_rd_addr = 7; i_rs1_addr = 0; i_rs2_addr = 0;
        cyc();
        i_claim_en = 0; i_rs1_addr = 7;
        @(negedge clk);
        check("hz7_ready0", {31'd0, o_regfile_ready}, 32'd0);
        cyc();
        @(negedge clk);
        check("hz7_ready1", {31'd0, o_regfile_ready}, 32'd0);
        cyc();
        i_wen = 1; i_waddr = 7; i_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        check("hz7_bypass_ready", {31'd0, o_regfile_ready}, 32'd1);
        cyc();
        i_wen = 0;
        @(negedge clk);
        check("hz7_rs1",       o_rs1_data, 32'hA5A5A5A5);
        check("hz7_busy_free", {31'd0, o_regfile_ready}, 32'd1);
        cyc();
        i_decoder_valid = 0;
        cyc();

        // backpressure: outputs hold while executor stalls
        i_executor_ready = 0; i_decoder_valid = 1; i_rs1_addr = 5; i_rs2_addr = 7;
        cyc();
        i_rs1_addr = 7; i_rs2_addr = 5;
        @(negedge clk);
        check("bp_ready0", {31'd0, o_regfile_ready}, 32'd0);
        check("bp_rs1a",   o_rs1_data, 32'hDEADBEEF);
        cyc();
        @(negedge clk);
        check("bp_rs1b",  o_rs1_data, 32'hDEADBEEF);
        check("bp_rs2b",  o_rs2_data, 32'hA5A5A5A5);
        check("bp_valid", {31'd0, o_regfile_valid}, 32'd1);
        i_executor_ready = 1;
        #1;
        check("bp_release_ready", {31'd0, o_regfile_ready}, 32'd1);
        cyc();
        i_decoder_valid = 0;
        @(negedge clk);
        check("bp_new_rs1", o_rs1_data, 32'hA5A5A5A5);
        check("bp_new_rs2", o_rs2_data, 32'hDEADBEEF);
        cyc();

        // claim x3 then flush
        i_decoder_valid = 1; i_claim_en = 1; i_rd_addr = 3; i_rs1_addr = 0; i_rs2_addr = 0;
        cyc();
        i_decoder_valid = 0; i_claim_en = 0; i_flush = 1;
        @(negedge clk);
        check("fl_ready", {31'd0, o_regfile_ready}, 32'd0);
        cyc();
        i_flush = 0; i_decoder_valid = 1; i_rs1_addr = 3;
        @(negedge clk);
        check("fl_valid", {31'd0, o_regfile_valid}, 32'd0);
        check("fl_ready3", {31'd0, o_regfile_ready}, 32'd1);
        cyc();
        i_decoder_valid = 0;
        @(negedge clk);
        check("fl_acc_valid", {31'd0, o_regfile_valid}, 32'd1);
        cyc();

        // reset mid-stream with valid pair and busy x9
        i_wen = 1; i_waddr = 9; i_wdata = 32'h00000099;
        cyc();
        i_wen = 0; i_decoder_valid = 1; i_claim_en = 1; i_rd_addr = 9; i_rs1_addr = 9;
        cyc();
        i_decoder_valid = 0; i_claim_en = 0;
        check("mr_pre_valid", {31'd0, o_regfile_valid}, 32'd1);
        check("mr_pre_rs1",   o_rs1_data, 32'h00000099);
        #1 rst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, o_regfile_valid}, 32'd0);
        check("mr_rs1",   o_rs1_data, 32'd0);
        check("mr_ready", {31'd0, o_regfile_ready}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();
        i_decoder_valid = 1; i_rs1_addr = 9; i_rs2_addr = 0;
        @(negedge clk);
        check("mr_ready9", {31'd0, o_regfile_ready}, 32'd1);
        cyc();
        idle();
        @(negedge clk);
        check("mr_rs1_9", o_rs1_data, 32'd0);
        cyc();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int hi;
            hi = ($urandom_range(0, 7) == 0) ? 31 : 7;
            i_wen            = ($urandom_range(0, 2) == 0);
            i_waddr          = 5'($urandom_range(0, hi));
            i_wdata          = $urandom;
            i_decoder_valid  = ($urandom_range(0, 3) != 0);
            i_rs1_addr       = 5'($urandom_range(0, hi));
            i_rs2_addr       = 5'($urandom_range(0, hi));
            i_claim_en       = ($urandom_range(0, 1) == 1);
            i_rd_addr        = 5'($urandom_range(0, hi));
            i_flush          = ($urandom_range(0, 40) == 0);
            i_executor_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle();
        repeat (3) cyc();
        cmp_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 32 bits and the register count at 32 (x0..x31).
REQ-002 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset.
REQ-004 wen  input  1  Write strobe from the writeback stage.
REQ-005 waddr  input  5  Write register index.
REQ-006 wdata  input  32  Write data.
REQ-007 decoder_valid  input  1  The decoder presents a read request.
REQ-008 regfile_ready  output  1  Combinational; the request is accepted this cycle.
REQ-009 rs1_addr, rs2_addr  input  5 each  Source register indices.
REQ-010 claim_en  input  1  The request writes rd_addr later.
REQ-011 rd_addr  input  5  Destination index to mark busy.
REQ-012 flush  input  1  Pipeline flush.
REQ-013 regfile_valid  output  1  Registered; rs1_data/rs2_data hold a valid operand pair.
REQ-014 executor_ready  input  1  Downstream consumes the operand pair.
REQ-015 rs1_data, rs2_data  output  32 each  Registered operand values.

Function
REQ-016 Storage SHALL be 31 writable 32-bit registers; x0 SHALL always read 0, and a write to x0 SHALL be discarded.
REQ-017 When wen=1 and waddr!=0, regs[waddr] SHALL take wdata at the clock edge.
REQ-018 A scoreboard busy[31:1] SHALL track pending destinations; busy[0] SHALL be constant 0.
REQ-019 hazard SHALL be asserted for a source with addr!=0 and busy[addr]=1, unless wen=1 and waddr==addr in the same cycle.
REQ-020 regfile_ready SHALL equal !reset_active && !flush && !hazard(rs1) && !hazard(rs2) && (!regfile_valid || executor_ready).
REQ-021 accept SHALL be decoder_valid && regfile_ready; on accept, rs1_data/rs2_data SHALL load the source values and regfile_valid SHALL be 1 the next cycle (1-cycle latency).
REQ-022 Source values SHALL be bypassed: when wen=1 and waddr==src!=0 in the accept cycle, wdata SHALL be captured instead of the stored value.
REQ-023 On accept with claim_en=1 and rd_addr!=0, busy[rd_addr] SHALL be set.
REQ-024 When wen=1 and waddr!=0, busy[waddr] SHALL be cleared; if the same cycle sets busy for the same index, set SHALL win.
REQ-025 regfile_valid SHALL clear when regfile_valid && executor_ready && !accept; otherwise it SHALL hold, and rs1_data/rs2_data SHALL be stable while regfile_valid=1 and executor_ready=0.
REQ-026 flush=1 SHALL clear all busy bits and regfile_valid next cycle, SHALL block accept, and SHALL NOT block register writes.
REQ-027 claim_en with rd_addr equal to a source SHALL still read the old value (the claim does not affect the same request's hazard check).

Reset
REQ-028 While reset=0, all registers SHALL be 0, all busy bits 0, regfile_valid 0, rs1_data/rs2_data 0, and regfile_ready 0, asynchronously.
REQ-029 Writes and requests presented during reset SHALL be ignored; on deassertion, operation SHALL resume on the next rising edge.

Verification
REQ-030 Write x5=0xDEADBEEF, then a request with rs1=5, rs2=0 -> one cycle later regfile_valid=1, rs1_data=0xDEADBEEF, rs2_data=0.
REQ-031 Write x0=0x12345678, then read rs1=0 -> rs1_data=0.
REQ-032 Accept with claim_en=1, rd=7; next request rs1=7 -> regfile_ready=0 until wen=1, waddr=7, wdata=0xA5A5A5A5; in that cycle ready=1 and rs1_data=0xA5A5A5A5 (bypass); busy[7] is then 0.
REQ-033 Hold executor_ready=0 with regfile_valid=1 and decoder_valid=1 -> regfile_ready=0 and outputs stable; raise executor_ready -> the new pair is accepted in that cycle.
REQ-034 Claim rd=3, then pulse flush -> busy cleared, regfile_valid=0; a request rs1=3 is accepted on the next cycle.
REQ-035 Assert reset mid-stream with regfile_valid=1 and busy[9]=1 -> outputs 0 immediately and a read of x9 after release returns 0.
